// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state and LSU size codes for the data-memory controller.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [1:0] SZ_B    = 2'b00;
    localparam logic [1:0] SZ_H    = 2'b01;
    localparam logic [1:0] SZ_W    = 2'b10;
    localparam logic [1:0] SZ_NONE = 2'b11;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane enables, store placement, load extraction and misalign flag.
// Misalign flag is only raised when DMEM_MISALIGN_TRAP_EN is defined.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_sh,
    output logic        misalign
);

    logic [1:0] off;
    logic [4:0] sh;

    always_comb begin
        off      = (size == SZ_B) ? addr_lo : (size == SZ_H) ? {addr_lo[1], 1'b0} : 2'b00;
        sh       = {off, 3'b000};
        be       = (size == SZ_B) ? 4'b0001 << off :
                   (size == SZ_H) ? 4'b0011 << off :
                   (size == SZ_W) ? 4'b1111 : 4'b0000;
        wdata_sh = wdata << sh;
        rdata_sh = (rdata >> sh) & ((size == SZ_B) ? 32'h0000_00FF :
                                    (size == SZ_H) ? 32'h0000_FFFF : 32'hFFFF_FFFF);
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = ((size == SZ_H) & addr_lo[0]) | ((size == SZ_W) & (addr_lo != 2'b00));
`else
        misalign = 1'b0;
`endif
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: M-stage data-memory controller with req/ack bus handshake, timeout and stall.
// Optional DMEM_MISALIGN_TRAP_EN aborts misaligned half/word accesses without a bus request.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 5
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_en_M,
    input  logic        store_M,
    input  logic [1:0]  size_M,
    input  logic [31:0] addr_M,
    input  logic [31:0] wdata_M,
    output logic [31:0] Rdata_M,
    output logic        stall_M,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state_q, state_d;
    logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]      be_q, be_d;
    logic            we_q, we_d, err_q, err_d;
    logic [1:0]      size_q, size_d, off_q, off_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            start, timeout;
    logic [1:0]      al_size, al_off;
    logic [3:0]      al_be;
    logic [31:0]     al_wdata, al_rdata;
    logic            al_mis;

    // Live inputs drive the aligner while idle; the latched access drives it while on the bus.
    assign al_size = (state_q == IDLE) ? size_M : size_q;
    assign al_off  = (state_q == IDLE) ? addr_M[1:0] : off_q;

    dmem_lane_align u_align (
        .size     (al_size),
        .addr_lo  (al_off),
        .wdata    (wdata_M),
        .rdata    (bus_rdata),
        .be       (al_be),
        .wdata_sh (al_wdata),
        .rdata_sh (al_rdata),
        .misalign (al_mis)
    );

    always_comb begin
        start   = rst_n & mem_en_M & (size_M != SZ_NONE) & (state_q == IDLE);
        timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        be_d    = be_q;
        we_d    = we_q;
        size_d  = size_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                addr_d  = {addr_M[31:2], 2'b00};
                wdata_d = al_wdata;
                be_d    = al_be;
                we_d    = store_M;
                size_d  = size_M;
                off_d   = addr_M[1:0];
                cnt_d   = '0;
                rdata_d = '0;
                err_d   = al_mis;
                state_d = al_mis ? DONE : REQ;
            end
            REQ: if (bus_ack) begin
                rdata_d = we_q ? 32'h0 : al_rdata;
                state_d = DONE;
            end else if (timeout) begin
                err_d   = 1'b1;
                state_d = DONE;
            end else begin
                cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            size_q  <= size_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus_req   = (state_q == REQ);
    assign stall_M   = start | bus_req;
    assign bus_err   = err_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign Rdata_M   = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed self-checking bench for dmem_ctrl (TIMEOUT_CYCLES=16).
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, mem_en_M, store_M, bus_ack;
    logic [1:0]  size_M;
    logic [31:0] addr_M, wdata_M, bus_rdata;
    logic [31:0] Rdata_M, bus_addr, bus_wdata;
    logic        stall_M, bus_err, bus_req, bus_we;
    logic [3:0]  bus_be;

    int          checks = 0;
    int          errors = 0;
    int          stalls, reqs, first_req;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    logic        c_we;

    always #5 clk = ~clk;

    dmem_ctrl #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_en_M  (mem_en_M),
        .store_M   (store_M),
        .size_M    (size_M),
        .addr_M    (addr_M),
        .wdata_M   (wdata_M),
        .Rdata_M   (Rdata_M),
        .stall_M   (stall_M),
        .bus_err   (bus_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // Runs one access from IDLE; returns in the DONE cycle (or after a 40-cycle bound).
    task automatic access(input logic st, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
        mem_en_M = 1'b1; store_M = st; size_M = sz; addr_M = a; wdata_M = wd; bus_rdata = rd;
        stalls = 0; reqs = 0; first_req = -1;
        c_addr = '0; c_wdata = '0; c_be = '0; c_we = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!stall_M) break;
            stalls++;
            if (bus_req) begin
                if (reqs == 0) begin
                    first_req = i; c_addr = bus_addr; c_wdata = bus_wdata; c_be = bus_be; c_we = bus_we;
                end
                reqs++;
                bus_ack = (reqs == ack_at);
            end
            @(posedge clk);
            #1;
            if (reqs > 0) bus_ack = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_en_M = 1'b0; store_M = 1'b0; size_M = SZ_B;
        addr_M = '0; wdata_M = '0; bus_rdata = '0; bus_ack = 1'b0;
        #12;
        chk("rst_req", bus_req, 0);
        chk("rst_we", bus_we, 0);
        chk("rst_stall", stall_M, 0);
        chk("rst_err", bus_err, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_be", bus_be, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_rdata", Rdata_M, 0);
        rst_n = 1'b1;
        cyc();

        access(1'b1, SZ_B, 32'h0000_1003, 32'h0000_00AB, 32'hFFFF_FFFF, 1);
        chk("sb_stalls", stalls, 2);
        chk("sb_addr", c_addr, 32'h0000_1000);
        chk("sb_be", c_be, 4'b1000);
        chk("sb_wdata", c_wdata, 32'hAB00_0000);
        chk("sb_we", c_we, 1);
        chk("sb_rdata", Rdata_M, 0);
        chk("sb_err", bus_err, 0);
        chk("sb_req_done", bus_req, 0);
        mem_en_M = 1'b0;
        cyc();

        access(1'b0, SZ_H, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 4);
        chk("lh_stalls", stalls, 5);
        chk("lh_reqs", reqs, 4);
        chk("lh_addr", c_addr, 32'h0000_2000);
        chk("lh_be", c_be, 4'b1100);
        chk("lh_we", c_we, 0);
        chk("lh_rdata", Rdata_M, 32'h0000_BEEF);
        chk("lh_err", bus_err, 0);
        mem_en_M = 1'b0;
        cyc();

        access(1'b0, SZ_W, 32'h0000_3000, 32'h0, 32'h5555_5555, 0);
        chk("to_stalls", stalls, 17);
        chk("to_reqs", reqs, 16);
        chk("to_err", bus_err, 1);
        chk("to_rdata", Rdata_M, 0);
        chk("to_req_done", bus_req, 0);
        mem_en_M = 1'b0;
        cyc();
        chk("to_err_pulse", bus_err, 0);
        chk("to_req_after", bus_req, 0);

        access(1'b0, SZ_W, 32'h0000_6000, 32'h0, 32'h1234_5678, 16);
        chk("ackto_stalls", stalls, 17);
        chk("ackto_err", bus_err, 0);
        chk("ackto_rdata", Rdata_M, 32'h1234_5678);
        mem_en_M = 1'b0;
        cyc();

        bus_ack = 1'b1;
        cyc();
        chk("idle_ack_stall", stall_M, 0);
        chk("idle_ack_req", bus_req, 0);
        cyc();
        chk("idle_ack_err", bus_err, 0);
        chk("idle_ack_rdata", Rdata_M, 32'h1234_5678);
        bus_ack = 1'b0;

        access(1'b1, SZ_W, 32'h0000_5000, 32'h1122_3344, 32'h0, 1);
        chk("b2b_sw_stalls", stalls, 2);
        chk("b2b_sw_be", c_be, 4'b1111);
        chk("b2b_sw_wdata", c_wdata, 32'h1122_3344);
        bus_ack = 1'b1;
        cyc();
        access(1'b0, SZ_B, 32'h0000_5001, 32'h0, 32'hCAFE_F00D, 2);
        chk("b2b_first_req", first_req, 1);
        chk("b2b_lb_reqs", reqs, 2);
        chk("b2b_lb_stalls", stalls, 3);
        chk("b2b_lb_be", c_be, 4'b0010);
        chk("b2b_lb_we", c_we, 0);
        chk("b2b_lb_rdata", Rdata_M, 32'h0000_00F0);
        mem_en_M = 1'b0;
        cyc();

        access(1'b0, SZ_W, 32'h0000_4002, 32'h0, 32'hDEAD_BEEF, 1);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("mis_reqs", reqs, 0);
        chk("mis_stalls", stalls, 1);
        chk("mis_err", bus_err, 1);
        chk("mis_rdata", Rdata_M, 0);
`else
        chk("mis_reqs", reqs, 1);
        chk("mis_addr", c_addr, 32'h0000_4000);
        chk("mis_be", c_be, 4'b1111);
        chk("mis_err", bus_err, 0);
        chk("mis_rdata", Rdata_M, 32'hDEAD_BEEF);
`endif
        mem_en_M = 1'b0;
        cyc();

        mem_en_M = 1'b1; store_M = 1'b0; size_M = SZ_W; addr_M = 32'h0000_7000;
        cyc();
        chk("arst_req_before", bus_req, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_req", bus_req, 0);
        chk("arst_stall", stall_M, 0);
        cyc();
        chk("arst_req_held", bus_req, 0);
        size_M = SZ_NONE;
        rst_n = 1'b1;
        #1;
        chk("none_stall", stall_M, 0);
        cyc();
        chk("none_req", bus_req, 0);
        chk("none_stall_next", stall_M, 0);
        mem_en_M = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
